instruction_encoder: RTL
========================

# instruction_encoder

Packs decoded instruction fields into 32-bit GPU instruction words and streams them into instruction memory during a program load. It is the inverse of the instruction decode path: it accepts field tuples from the host/loader over a valid/ready handshake. Each accepted tuple becomes one registered memory write at consecutive addresses from a base address, and the encoder reports completion, word count and overflow.

## Interface
- ADDR_W, 8, instruction memory address width; depth is 2^ADDR_W words
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  begin a program load; honoured only in IDLE
- i_base_addr  in  ADDR_W  first write address, sampled with i_start
- i_valid  in  1  field tuple valid
- o_ready  out  1  encoder can accept a tuple this cycle
- i_opcode  in  5  opcode field
- i_rd_addr  in  4  destination register
- i_rs1_addr  in  4  source register 1
- i_rs2_addr  in  4  source register 2
- i_imm  in  12  immediate
- i_last  in  1  tuple is the final word of the program
- o_mem_we  out  1  instruction memory write enable
- o_mem_addr  out  ADDR_W  write address
- o_mem_wdata  out  32  encoded instruction word
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle pulse at end of load
- o_count  out  ADDR_W+1  words written in current/last load
- o_overflow  out  1  sticky; load truncated at top of memory

## Operation
- Word format: [31:27] opcode | [26:23] rd | [22:19] rs1 | [18:15] rs2 | [14:12] 3'b000 | [11:0] imm. Bits [14:12] are always written as zero.
- States are IDLE, LOAD and DONE.
- IDLE:
  - o_ready=0.
  - i_start → LOAD. Latch the write pointer to i_base_addr. Clear o_count and o_overflow.
- LOAD:
  - o_ready=1.
  - Accept occurs on i_valid&o_ready. An accepted tuple is encoded and registered into o_mem_addr/o_mem_wdata with o_mem_we=1 next cycle.
  - The pointer increments by 1 and o_count by 1.
  - Accept with i_last=1 → DONE.
  - Accept at pointer 2^ADDR_W-1 with i_last=0: the word is still written, o_overflow is set, and the state goes → DONE. There is no wrap to address 0.
- DONE:
  - o_ready=0 and o_done=1 for exactly one cycle, then → IDLE.
- i_start outside IDLE is ignored. It does not restart the load or re-sample the base.
- i_valid without o_ready is not consumed. The tuple must be held by the source (standard valid/ready).
- o_mem_we is 0 in every cycle not directly following an accept.
- Reset values are state=IDLE and all outputs 0: o_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_busy, o_done, o_count, o_overflow.
- Reset mid-load drops any pending write. No o_done is produced, and o_count and o_overflow clear.

## Timing
- i_start at cycle T → o_busy=1 and o_ready=1 from T+1.
- Accept at cycle N → o_mem_we/o_mem_addr/o_mem_wdata valid at N+1, and o_count updated at N+1. Latency is 1 cycle.
- Back-to-back accepts give back-to-back writes, sustaining 1 word/cycle.
- Last accept at N:
  - o_ready=0 at N+1.
  - o_done=1 coincides with the final write at N+1.
  - o_busy=0 at N+2.
  - A new i_start is honoured from N+2.
- o_overflow rises at N+1 together with the final write and o_done. It holds until the next honoured i_start or reset.

## Structure
- Shared package gpu_isa_pkg holds:
  - field bit positions and widths (OPCODE_MSB/LSB, RD_, RS1_, RS2_, IMM_)
  - an opcode_t typedef
  - a pure function pack_instr(opcode, rd, rs1, rs2, imm) returning the 32-bit word
- The decoder is to use the same constants.
- There is no sub-module; the encode is the package function. The FSM, pointer, counter and output register live in instruction_encoder.

## Test plan
- Single word: start with base=8'h10; tuple opcode=5'h03, rd=4'h2, rs1=4'h5, rs2=4'hA, imm=12'hABC, last=1 → one write addr=8'h10, data=32'h192D0ABC; o_done pulse on same cycle; o_count=1.
- Field isolation: all fields all-ones → data=32'hFFFF8FFF (bits [14:12] zero); decoder round-trip returns identical fields.
- Stream with backpressure gaps: 4 tuples with i_valid dropped for 2 cycles mid-stream from base 8'h20 → writes at 8'h20..8'h23 only on accept+1 cycles; o_count=4; o_mem_we never high during gaps.
- Overflow: base=8'hFE, 3 tuples, none with i_last → writes at FE and FF; o_overflow=1 and o_done on the FF write; third tuple is not accepted (o_ready=0); no write to 8'h00.
- Ignored start: i_start pulsed during LOAD with a different base → addresses continue from the original base.
- Async reset mid-load: assert i_rst between accept and write → o_mem_we=0 immediately; all outputs 0; no o_done; a fresh load then works normally.

Source files
------------

// File: rtl/gpu_isa_pkg.sv
// GPU instruction-word layout shared by the encoder and the decode path.
// Field positions live here so that both sides agree on the format.
package gpu_isa_pkg;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam int RD_MSB     = 26;
  localparam int RD_LSB     = 23;
  localparam int RS1_MSB    = 22;
  localparam int RS1_LSB    = 19;
  localparam int RS2_MSB    = 18;
  localparam int RS2_LSB    = 15;
  localparam int IMM_MSB    = 11;
  localparam int IMM_LSB    = 0;

  typedef logic [4:0]  opcode_t;
  typedef logic [3:0]  reg_addr_t;
  typedef logic [11:0] imm_t;
  typedef logic [31:0] instr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } enc_state_t;

  // Bits [14:12] are reserved and always packed as zero.
  function automatic instr_t pack_instr(opcode_t opcode, reg_addr_t rd,
                                        reg_addr_t rs1, reg_addr_t rs2, imm_t imm);
    instr_t w;
    w = '0;
    w[OPCODE_MSB:OPCODE_LSB] = opcode;
    w[RD_MSB:RD_LSB]         = rd;
    w[RS1_MSB:RS1_LSB]       = rs1;
    w[RS2_MSB:RS2_LSB]       = rs2;
    w[IMM_MSB:IMM_LSB]       = imm;
    return w;
  endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Loader-side tuple handshake plus the instruction-memory write port and
// load status of the instruction encoder.
interface instruction_encoder_if #(
  parameter int ADDR_W = 8
);
  import gpu_isa_pkg::*;

  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr;
  logic              i_valid;
  logic              o_ready;
  opcode_t           i_opcode;
  reg_addr_t         i_rd_addr;
  reg_addr_t         i_rs1_addr;
  reg_addr_t         i_rs2_addr;
  imm_t              i_imm;
  logic              i_last;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  instr_t            o_mem_wdata;
  logic              o_busy;
  logic              o_done;
  logic [ADDR_W:0]   o_count;
  logic              o_overflow;

  modport master (
    output i_start, i_base_addr, i_valid, i_opcode, i_rd_addr, i_rs1_addr,
           i_rs2_addr, i_imm, i_last,
    input  o_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_busy, o_done,
           o_count, o_overflow
  );

  modport slave (
    input  i_start, i_base_addr, i_valid, i_opcode, i_rd_addr, i_rs1_addr,
           i_rs2_addr, i_imm, i_last,
    output o_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_busy, o_done,
           o_count, o_overflow
  );

endinterface

// File: rtl/instruction_encoder.sv
// Packs accepted field tuples into instruction words and writes them to
// consecutive instruction-memory addresses, one registered write per accept.
module instruction_encoder
  import gpu_isa_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input logic                   i_clk,
  input logic                   i_rst,
  instruction_encoder_if.slave  bus
);

  enc_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  instr_t            r_wdata;

  logic w_accept;
  logic w_at_top;
  logic w_ready;
  logic w_busy;
  logic w_done;

  assign w_accept = bus.i_valid && w_ready;
  assign w_at_top = &r_ptr;

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (bus.i_start) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_ready = 1'b1;
        // The top word is still written, but the load ends there rather than wrapping.
        if (bus.i_valid && (bus.i_last || w_at_top)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_we <= w_accept;
      if (r_state == ST_IDLE && bus.i_start) begin
        r_ptr      <= bus.i_base_addr;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end
      if (w_accept) begin
        r_addr  <= r_ptr;
        r_wdata <= pack_instr(bus.i_opcode, bus.i_rd_addr, bus.i_rs1_addr,
                              bus.i_rs2_addr, bus.i_imm);
        r_ptr   <= r_ptr + ADDR_W'(1);
        r_count <= r_count + (ADDR_W+1)'(1);
        if (w_at_top && !bus.i_last) r_overflow <= 1'b1;
      end
    end
  end

  assign bus.o_ready     = w_ready;
  assign bus.o_busy      = w_busy;
  assign bus.o_done      = w_done;
  assign bus.o_mem_we    = r_we;
  assign bus.o_mem_addr  = r_addr;
  assign bus.o_mem_wdata = r_wdata;
  assign bus.o_count     = r_count;
  assign bus.o_overflow  = r_overflow;

endmodule
